// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA-style raster timing generator.
// Walks a horizontal/vertical counter pair at the pixel tick (ena) and
// produces registered hsync/vsync/de plus line/frame start pulses.
// Optional feature: define VGA_SYNC_GEN_FRAME_CNT_EN to add an 8-bit
// frame counter output (frame_cnt) that steps with every frame_start.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOT),
    localparam int YW      = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    // Sync windows as half-open ranges [BEG, END); END == BEG means no sync.
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    // Raw position counters; they park at the last pixel of the last line
    // in reset so the very first tick lands on (0,0).
    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          h_wrap;

    // Output registers, loaded from the *next* position so they line up
    // with the counters in the clk after the tick.
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [7:0]    frame_cnt_q;
`endif

    // Next position and the decoded levels/pulses that belong to it.
    always_comb begin
        h_wrap        = (h_q == XW'(H_TOT - 1));
        h_d           = h_wrap ? '0 : h_q + 1'b1;
        v_d           = v_q;
        if (h_wrap) begin
            v_d = (v_q == YW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
        end
        hsync_d       = (int'(h_d) >= HS_BEG && int'(h_d) < HS_END) ? H_POL : ~H_POL;
        vsync_d       = (int'(v_d) >= VS_BEG && int'(v_d) < VS_END) ? V_POL : ~V_POL;
        de_d          = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
        line_start_d  = (h_d == '0);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    // Advance on the pixel tick; pulses self-clear on every other clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= XW'(H_TOT - 1);
            v_q           <= YW'(V_TOT - 1);
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
            frame_cnt_q   <= 8'd0;
`endif
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (ena) begin
                h_q           <= h_d;
                v_q           <= v_d;
                x_q           <= h_d;
                y_q           <= v_d;
                hsync_q       <= hsync_d;
                vsync_q       <= vsync_d;
                de_q          <= de_d;
                line_start_q  <= line_start_d;
                frame_start_q <= frame_start_d;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
                if (frame_start_d) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
`endif
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- directed bench for vga_sync_gen on small timings.
// DUT A: H 8/2/3/2 (H_TOT=15), V 4/1/2/1 (V_TOT=8), active-low syncs.
// DUT B: same but H_SYNC=0 (H_TOT=12) -> hsync must never assert.
// Build with VGA_SYNC_GEN_FRAME_CNT_EN defined to also check frame_cnt.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;

    logic       hsync, vsync, de, line_start, frame_start;
    logic [3:0] x;
    logic [2:0] y;
    logic       hsync2, vsync2, de2, line_start2, frame_start2;
    logic [3:0] x2;
    logic [2:0] y2;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [7:0] frame_cnt, frame_cnt2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference position (spec counters) and expected registered outputs.
    int         mh, mv, m2h, m2v;
    int         e_x, e_y, e_x2, e_y2;
    logic       e_hs, e_vs, e_de, e_ls, e_fs;
    logic       e_hs2, e_vs2, e_de2, e_ls2, e_fs2;
    logic [7:0] e_fc;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(0), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_dut_nohs (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(hsync2), .vsync(vsync2), .de(de2), .x(x2), .y(y2),
        .line_start(line_start2), .frame_start(frame_start2)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        , .frame_cnt(frame_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state right after reset: counters parked at the frame end.
    task automatic model_reset();
        mh = 14; mv = 7; m2h = 11; m2v = 7;
        e_x = 0; e_y = 0; e_x2 = 0; e_y2 = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        e_hs2 = 1'b1; e_vs2 = 1'b1; e_de2 = 1'b0; e_ls2 = 1'b0; e_fs2 = 1'b0;
        e_fc = 8'd0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".x"}, 32'(x), 32'(e_x));
        chk({ph, ".y"}, 32'(y), 32'(e_y));
        chk({ph, ".hsync"}, 32'(hsync), 32'(e_hs));
        chk({ph, ".vsync"}, 32'(vsync), 32'(e_vs));
        chk({ph, ".de"}, 32'(de), 32'(e_de));
        chk({ph, ".line_start"}, 32'(line_start), 32'(e_ls));
        chk({ph, ".frame_start"}, 32'(frame_start), 32'(e_fs));
        chk({ph, ".x2"}, 32'(x2), 32'(e_x2));
        chk({ph, ".y2"}, 32'(y2), 32'(e_y2));
        chk({ph, ".hsync2"}, 32'(hsync2), 32'(e_hs2));
        chk({ph, ".vsync2"}, 32'(vsync2), 32'(e_vs2));
        chk({ph, ".de2"}, 32'(de2), 32'(e_de2));
        chk({ph, ".line_start2"}, 32'(line_start2), 32'(e_ls2));
        chk({ph, ".frame_start2"}, 32'(frame_start2), 32'(e_fs2));
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        chk({ph, ".frame_cnt"}, 32'(frame_cnt), 32'(e_fc));
        chk({ph, ".frame_cnt2"}, 32'(frame_cnt2), 32'(e_fc));
`endif
    endtask

    // One clk with the given ena; sample 1 time unit after the edge.
    task automatic step(input string ph, input bit e);
        ena = e;
        @(posedge clk);
        #1;
        e_ls = 1'b0; e_fs = 1'b0; e_ls2 = 1'b0; e_fs2 = 1'b0;
        if (e) begin
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e_x  = mh; e_y = mv;
            e_de = (mh < 8) && (mv < 4);
            e_hs = !(mh >= 10 && mh <= 12);
            e_vs = !(mv >= 5 && mv <= 6);
            e_ls = (mh == 0);
            e_fs = (mh == 0) && (mv == 0);
            if (e_fs) e_fc = e_fc + 8'd1;
            if (m2h == 11) begin
                m2h = 0;
                m2v = (m2v == 7) ? 0 : m2v + 1;
            end else begin
                m2h = m2h + 1;
            end
            e_x2  = m2h; e_y2 = m2v;
            e_de2 = (m2h < 8) && (m2v < 4);
            e_hs2 = 1'b1;
            e_vs2 = !(m2v >= 5 && m2v <= 6);
            e_ls2 = (m2h == 0);
            e_fs2 = (m2h == 0) && (m2v == 0);
        end
        check_all(ph);
    endtask

    initial begin
        int last_fs, last_ls2, vlow, hlow;
        rst_n = 1'b0;
        ena   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Release, then run two full frames at constant ena.
        rst_n = 1'b1;
        last_fs = -1; last_ls2 = -1; vlow = 0; hlow = 0;
        for (int i = 0; i < 240; i++) begin
            step("run", 1'b1);
            if (frame_start) begin
                if (last_fs >= 0) chk("fs_period", 32'(i - last_fs), 32'd120);
                last_fs = i;
            end
            if (line_start2) begin
                if (last_ls2 >= 0) chk("line2_period", 32'(i - last_ls2), 32'd12);
                last_ls2 = i;
            end
            if (i < 120 && !vsync) vlow++;
            if (i < 15 && !hsync) hlow++;
        end
        chk("vs_low_clks", 32'(vlow), 32'd30);
        chk("hs_low_clks", 32'(hlow), 32'd3);

        // Pixel tick every second clk: pulses stay one clk, levels hold.
        for (int i = 0; i < 20; i++) begin
            step("toggle", 1'b1);
            step("toggle", 1'b0);
        end

        // Move to (6,2) and reset mid-frame.
        for (int i = 0; i < 200 && !(mh == 6 && mv == 2); i++) step("seek", 1'b1);
        chk("pre_rst_x", 32'(x), 32'd6);
        chk("pre_rst_y", 32'(y), 32'd2);
        ena   = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("in_rst");
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0);
        step("post_rst_first", 1'b1);
        chk("first_fs", 32'(frame_start), 32'd1);

        // 256 further frames: frame_cnt rolls 255 -> 0 -> 1.
        for (int i = 0; i < 256 * 120; i++) step("frames", 1'b1);
        chk("frame257_fs", 32'(frame_start), 32'd1);
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        chk("frame257_cnt", 32'(frame_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width (pixels).
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch (lines).
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width (lines).
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch (lines).
REQ-009 SHALL have parameter H_POL, default 0, hsync asserted level.
REQ-010 SHALL have parameter V_POL, default 0, vsync asserted level.
REQ-011 SHALL define the derived values H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOT likewise, XW=clog2(H_TOT) and YW=clog2(V_TOT).
REQ-012 SHALL have port clk, input, 1, the single clock.
REQ-013 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-014 SHALL have port ena, input, 1, pixel tick; the position advances only on cycles where ena=1.
REQ-015 SHALL have port hsync, output, 1, horizontal sync.
REQ-016 SHALL have port vsync, output, 1, vertical sync.
REQ-017 SHALL have port de, output, 1, display enable (pixel visible).
REQ-018 SHALL have port x, output, XW, current horizontal counter.
REQ-019 SHALL have port y, output, YW, current vertical counter.
REQ-020 SHALL have port line_start, output, 1, one-clk pulse at x=0.
REQ-021 SHALL have port frame_start, output, 1, one-clk pulse at (0,0).
REQ-022 SHALL have port frame_cnt, output, 8, frame counter; present only with VGA_SYNC_GEN_FRAME_CNT_EN defined.

Function
REQ-023 SHALL keep internal counters h in 0..H_TOT-1 and v in 0..V_TOT-1.
REQ-024 On ena=1: h increments; if h=H_TOT-1, h wraps to 0 and v increments; if v=V_TOT-1 on that wrap, v wraps to 0.
REQ-025 On ena=0: counters and all level outputs SHALL hold.
REQ-026 All outputs SHALL be registered and reflect the new (h,v) in the clk after the ena=1 edge that produced it.
REQ-027 x=h and y=v at all times (raw counters, not blanked).
REQ-028 de=1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-029 hsync=H_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !H_POL.
REQ-030 vsync=V_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else !V_POL; vsync changes only together with the h wrap.
REQ-031 line_start=1 for exactly one clk after an ena edge that moved h to 0; frame_start is likewise gated on (0,0); both SHALL clear on the next clk regardless of ena.
REQ-032 Degenerate parameters (any porch or sync equal to 0) SHALL be supported; a zero-width sync never asserts.

Reset
REQ-033 rst_n=0 SHALL asynchronously set h=H_TOT-1 and v=V_TOT-1, so that the first ena after reset yields (0,0) together with a frame_start pulse.
REQ-034 During reset, outputs SHALL be: hsync=!H_POL, vsync=!V_POL, de=0, line_start=0, frame_start=0, x=0, y=0, frame_cnt=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; no partial pulse SHALL be emitted after release.

Configuration
REQ-036 With VGA_SYNC_GEN_FRAME_CNT_EN defined, frame_cnt SHALL increment (mod 256) in the same clk that frame_start asserts; the first frame after reset reads 1.
REQ-037 Without VGA_SYNC_GEN_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification (small parameters: H 8/2/3/2 -> H_TOT=15; V 4/1/2/1 -> V_TOT=8; POL=0)
REQ-038 Release reset, ena=1 constantly -> first output (x,y)=(0,0), frame_start=1, line_start=1, de=1; frame_start recurs every 120 clks.
REQ-039 Constant ena -> hsync=0 exactly for x=10..12, de=1 for x=0..7 on y=0..3; vsync=0 for y=5..6 (30 clks).
REQ-040 ena toggling 1,0,1,0 -> x advances every second clk; each pulse is 1 clk wide; outputs hold on ena=0.
REQ-041 Assert rst_n=0 at (x,y)=(6,2), release, ena=1 -> (0,0) with frame_start=1 next; no stale line_start.
REQ-042 With VGA_SYNC_GEN_FRAME_CNT_EN, run 257 frames -> frame_cnt reads 1,2,...,255,0,1.
REQ-043 Parameter H_SYNC=0 -> hsync never asserts; H_TOT=12 and line period = 12 clks.
